// File: rtl/shifter_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe_if
//  Description : Request/response bundle for the pipelined ARM operand-2
//                shifter. The request side is a valid/ready handshake that
//                carries the raw instruction fields. The response side is a
//                valid/ready handshake that carries the shifted operand and
//                the shifter carry-out.
//  Ports (as seen from the slave / shifter side):
//      in_valid, mode, imm12, rs_amt, rm_data, branch_off, carry_in   (in)
//      in_ready                                                       (out)
//      out_ready                                                      (in)
//      out_valid, shifted_data, carry_out                             (out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface shifter_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int BRANCH_W = 24,
    parameter int AMT_W    = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          mode;
    logic [11:0]         imm12;
    logic [AMT_W-1:0]    rs_amt;
    logic [DATA_W-1:0]   rm_data;
    logic [BRANCH_W-1:0] branch_off;
    logic                carry_in;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   shifted_data;
    logic                carry_out;

    // Producer of requests / consumer of results.
    modport master (
        output in_valid, mode, imm12, rs_amt, rm_data, branch_off, carry_in,
        output out_ready,
        input  in_ready, out_valid, shifted_data, carry_out
    );

    // The shifter itself.
    modport slave (
        input  in_valid, mode, imm12, rs_amt, rm_data, branch_off, carry_in,
        input  out_ready,
        output in_ready, out_valid, shifted_data, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe
//  Description : Two-stage pipelined ARM operand-2 shifter with valid/ready
//                handshakes on both sides. Stage 1 decodes the four operand
//                encodings (immediate-rotate, immediate-shift, register-shift,
//                branch offset) into one normalised shift request. Stage 2
//                runs a log-stage barrel and the carry-out selection and
//                registers the result.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-low reset
//                bus    - shifter_pipe_if.slave (request + response)
//  Config      : SHIFTER_PIPE_CARRY_EN - when defined, the ARM shifter
//                carry-out is built; when undefined carry_out is tied to 0.
//  Assumes     : DATA_W is a power of two, >= 32 and > BRANCH_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe #(
    parameter int DATA_W   = 32,
    parameter int BRANCH_W = 24,
    parameter int AMT_W    = 8
) (
    input  wire           clk,
    input  wire           reset,
    shifter_pipe_if.slave bus
);

    localparam int c_IDX_W = $clog2(DATA_W);
    // Normalised amount spans 0..DATA_W inclusive, hence one extra bit.
    localparam int c_AMT_N = c_IDX_W + 1;

    // Normalised shift kinds carried from stage 1 to stage 2.
    localparam logic [2:0] c_K_LSL = 3'd0;
    localparam logic [2:0] c_K_LSR = 3'd1;
    localparam logic [2:0] c_K_ASR = 3'd2;
    localparam logic [2:0] c_K_ROR = 3'd3;
    localparam logic [2:0] c_K_RRX = 3'd4;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r1_valid;
    logic r2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv     = !r2_valid || bus.out_ready;
    assign w_s1_adv     = !r1_valid || w_s2_adv;
    assign bus.in_ready = reset && w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1 decode: every encoding becomes {kind, amount, over, operand}.
    // amount==0 always means "pass operand, keep carry_in"; over marks a
    // register shift larger than DATA_W where LSL/LSR give 0 with carry 0.
    // ------------------------------------------------------------------
    logic [2:0]         w_kind;
    logic [c_AMT_N-1:0] w_amt;
    logic               w_over;
    logic [DATA_W-1:0]  w_opnd;
    logic [DATA_W-1:0]  w_br_se;
    logic [4:0]         w_n;
    logic [31:0]        w_a;

    assign w_br_se = {{(DATA_W-BRANCH_W){bus.branch_off[BRANCH_W-1]}}, bus.branch_off};
    assign w_n     = bus.imm12[11:7];
    assign w_a     = 32'(bus.rs_amt);

    always_comb begin
        w_kind = c_K_LSL;
        w_amt  = '0;
        w_over = 1'b0;
        w_opnd = bus.rm_data;
        case (bus.mode)
            2'b00: begin
                w_kind = c_K_ROR;
                w_opnd = DATA_W'(bus.imm12[7:0]);
                w_amt  = c_AMT_N'({bus.imm12[11:8], 1'b0});
            end
            2'b01: begin
                case (bus.imm12[6:5])
                    2'b00: begin
                        w_kind = c_K_LSL;
                        w_amt  = c_AMT_N'(w_n);
                    end
                    2'b01: begin
                        // LSR #0 encodes LSR #DATA_W
                        w_kind = c_K_LSR;
                        w_amt  = (w_n == 5'd0) ? c_AMT_N'(DATA_W) : c_AMT_N'(w_n);
                    end
                    2'b10: begin
                        // ASR #0 encodes ASR #DATA_W
                        w_kind = c_K_ASR;
                        w_amt  = (w_n == 5'd0) ? c_AMT_N'(DATA_W) : c_AMT_N'(w_n);
                    end
                    default: begin
                        // ROR #0 encodes RRX
                        w_kind = (w_n == 5'd0) ? c_K_RRX : c_K_ROR;
                        w_amt  = c_AMT_N'(w_n);
                    end
                endcase
            end
            2'b10: begin
                case (bus.imm12[6:5])
                    2'b00, 2'b01: begin
                        w_kind = (bus.imm12[6:5] == 2'b00) ? c_K_LSL : c_K_LSR;
                        if (w_a >= 32'(DATA_W)) begin
                            w_amt  = c_AMT_N'(DATA_W);
                            w_over = (w_a > 32'(DATA_W));
                        end else begin
                            w_amt  = w_a[c_AMT_N-1:0];
                        end
                    end
                    2'b10: begin
                        w_kind = c_K_ASR;
                        w_amt  = (w_a >= 32'(DATA_W)) ? c_AMT_N'(DATA_W) : w_a[c_AMT_N-1:0];
                    end
                    default: begin
                        // A non-zero multiple of DATA_W is a full rotation:
                        // operand unchanged, carry = operand MSB.
                        w_kind = c_K_ROR;
                        if (w_a == 32'd0)
                            w_amt = '0;
                        else if (w_a[c_IDX_W-1:0] == '0)
                            w_amt = c_AMT_N'(DATA_W);
                        else
                            w_amt = {1'b0, w_a[c_IDX_W-1:0]};
                    end
                endcase
            end
            default: begin
                // Fixed <<2 is folded in here; amount 0 keeps carry_in.
                w_kind = c_K_LSL;
                w_opnd = w_br_se << 2;
            end
        endcase
    end

    logic [2:0]         r1_kind;
    logic [c_AMT_N-1:0] r1_amt;
    logic               r1_over;
    logic [DATA_W-1:0]  r1_opnd;
    logic               r1_cin;

    // ------------------------------------------------------------------
    // Stage 2: log-stage barrel, one conditional stage per amount bit.
    // The top stage shifts by exactly DATA_W (zero/sign fill, or identity
    // for rotate).
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_stg;
    logic [DATA_W-1:0] w_res;
    logic              w_cout;

    always_comb begin
        w_stg = r1_opnd;
        for (int k = 0; k < c_AMT_N; k++) begin
            if (r1_amt[k]) begin
                case (r1_kind)
                    c_K_LSL: w_stg = w_stg << (1 << k);
                    c_K_LSR: w_stg = w_stg >> (1 << k);
                    c_K_ASR: w_stg = DATA_W'($signed(w_stg) >>> (1 << k));
                    c_K_ROR: w_stg = (w_stg >> (1 << k)) | (w_stg << (DATA_W - (1 << k)));
                    default: w_stg = w_stg;
                endcase
            end
        end
        w_res = w_stg;
        if (r1_kind == c_K_RRX)
            w_res = {r1_cin, r1_opnd[DATA_W-1:1]};
        else if (r1_over)
            w_res = '0;
    end

`ifdef SHIFTER_PIPE_CARRY_EN
    // Carry is the last bit shifted out; indices wrap naturally so that an
    // amount of DATA_W selects bit 0 (LSL) or bit DATA_W-1 (LSR/ASR).
    logic [c_IDX_W-1:0] w_lidx;
    logic [c_IDX_W-1:0] w_ridx;

    assign w_lidx = c_IDX_W'(DATA_W - int'(r1_amt));
    assign w_ridx = c_IDX_W'(int'(r1_amt) - 1);

    always_comb begin
        w_cout = r1_cin;
        if (r1_kind == c_K_RRX) begin
            w_cout = r1_opnd[0];
        end else if (r1_amt != '0) begin
            if (r1_over) begin
                w_cout = 1'b0;
            end else begin
                case (r1_kind)
                    c_K_LSL:          w_cout = r1_opnd[w_lidx];
                    c_K_LSR, c_K_ASR: w_cout = r1_opnd[w_ridx];
                    c_K_ROR:          w_cout = w_res[DATA_W-1];
                    default:          w_cout = r1_cin;
                endcase
            end
        end
    end
`else
    assign w_cout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r2_data;
    logic              r2_cout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r1_valid <= 1'b0;
            r1_kind  <= c_K_LSL;
            r1_amt   <= '0;
            r1_over  <= 1'b0;
            r1_opnd  <= '0;
            r1_cin   <= 1'b0;
            r2_valid <= 1'b0;
            r2_data  <= '0;
            r2_cout  <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r1_kind <= w_kind;
                    r1_amt  <= w_amt;
                    r1_over <= w_over;
                    r1_opnd <= w_opnd;
                    r1_cin  <= bus.carry_in;
                end
            end
            if (w_s2_adv) begin
                r2_valid <= r1_valid;
                // Only real results overwrite the output, so bubbles never
                // disturb what the consumer last saw.
                if (r1_valid) begin
                    r2_data <= w_res;
                    r2_cout <= w_cout;
                end
            end
        end
    end

    assign bus.out_valid    = r2_valid;
    assign bus.shifted_data = r2_data;
    assign bus.carry_out    = r2_cout;

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_pipe
//  Description : Self-checking bench for shifter_pipe. A reference model
//                written directly from the ARM shifter rules predicts every
//                result; accepted requests are queued and checked in order
//                as they drain. Directed vectors cover every encoding and the
//                shift-amount boundaries, plus stall, back-pressure and
//                mid-flight reset. Honours SHIFTER_PIPE_CARRY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;

`ifdef SHIFTER_PIPE_CARRY_EN
    localparam bit C_CARRY = 1'b1;
`else
    localparam bit C_CARRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shifter_pipe_if #(.DATA_W(32), .BRANCH_W(24), .AMT_W(8)) bus ();

    shifter_pipe #(.DATA_W(32), .BRANCH_W(24), .AMT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_drained = 0;
    logic [32:0] q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v >> n) | (v << (32 - n));
    endfunction

    // Reference model: returns {carry, result}.
    function automatic logic [32:0] model(input logic [1:0] mode, input logic [11:0] imm,
                                          input logic [7:0] rs, input logic [31:0] rm,
                                          input logic [23:0] br, input logic cin);
        logic [31:0] r;
        logic        c;
        int          n;
        int          m;
        r = rm;
        c = cin;
        case (mode)
            2'd0: begin
                n = 2 * int'(imm[11:8]);
                r = ror32({24'd0, imm[7:0]}, n);
                c = (n == 0) ? cin : r[31];
            end
            2'd1: begin
                n = int'(imm[11:7]);
                case (imm[6:5])
                    2'd0: if (n != 0) begin r = rm << n; c = rm[32-n]; end
                    2'd1: if (n == 0) begin r = 0; c = rm[31]; end
                          else begin r = rm >> n; c = rm[n-1]; end
                    2'd2: if (n == 0) begin r = {32{rm[31]}}; c = rm[31]; end
                          else begin r = 32'($signed(rm) >>> n); c = rm[n-1]; end
                    default: if (n == 0) begin r = {cin, rm[31:1]}; c = rm[0]; end
                             else begin r = ror32(rm, n); c = rm[n-1]; end
                endcase
            end
            2'd2: begin
                n = int'(rs);
                if (n != 0) begin
                    case (imm[6:5])
                        2'd0: if (n < 32) begin r = rm << n; c = rm[32-n]; end
                              else begin r = 0; c = (n == 32) ? rm[0] : 1'b0; end
                        2'd1: if (n < 32) begin r = rm >> n; c = rm[n-1]; end
                              else begin r = 0; c = (n == 32) ? rm[31] : 1'b0; end
                        2'd2: if (n < 32) begin r = 32'($signed(rm) >>> n); c = rm[n-1]; end
                              else begin r = {32{rm[31]}}; c = rm[31]; end
                        default: begin
                            m = n % 32;
                            if (m == 0) begin r = rm; c = rm[31]; end
                            else begin r = ror32(rm, m); c = rm[m-1]; end
                        end
                    endcase
                end
            end
            default: begin
                r = {{8{br[23]}}, br} << 2;
                c = cin;
            end
        endcase
        return {c, r};
    endfunction

    // Scoreboard and output checker, sampled on the falling edge.
    logic        stall = 1'b0;
    logic [31:0] hold_d;
    logic        hold_c;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.shifted_data, hold_d);
                chk("hold_cout", bus.carry_out, hold_c);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got 0x%0h with nothing pending", bus.shifted_data);
                end else begin
                    e = q.pop_front();
                    chk("data", bus.shifted_data, e[31:0]);
                    chk("cout", bus.carry_out, C_CARRY ? e[32] : 1'b0);
                    n_drained++;
                end
            end
            stall  = bus.out_valid && !bus.out_ready;
            hold_d = bus.shifted_data;
            hold_c = bus.carry_out;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.mode, bus.imm12, bus.rs_amt, bus.rm_data,
                                  bus.branch_off, bus.carry_in));
        end
    end

    // Presents one request and holds it until accepted; returns 1 after the
    // accepting edge with in_valid still high.
    task automatic send(input logic [1:0] m, input logic [11:0] imm, input logic [7:0] rs,
                        input logic [31:0] rm, input logic [23:0] br, input logic cin);
        bit acc;
        int t;
        bus.in_valid   = 1'b1;
        bus.mode       = m;
        bus.imm12      = imm;
        bus.rs_amt     = rs;
        bus.rm_data    = rm;
        bus.branch_off = br;
        bus.carry_in   = cin;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at %0b", bus.in_ready);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q.size() != 0 || bus.out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        int base;
        logic [32:0] mv;
        bus.in_valid = 0; bus.mode = 0; bus.imm12 = 0; bus.rs_amt = 0;
        bus.rm_data = 0; bus.branch_off = 0; bus.carry_in = 0; bus.out_ready = 1;

        // Pin the model against hand-computed values.
        mv = model(2'd0, 12'h4FF, 8'd0, 32'h12345678, 24'd0, 1'b0);
        chk("model_rot", mv, {1'b1, 32'hFF000000});
        mv = model(2'd1, 12'h020, 8'd0, 32'h80000001, 24'd0, 1'b0);
        chk("model_lsr0", mv, {1'b1, 32'h00000000});
        mv = model(2'd1, 12'h060, 8'd0, 32'h00000003, 24'd0, 1'b1);
        chk("model_rrx", mv, {1'b1, 32'h80000001});
        mv = model(2'd2, 12'h000, 8'd32, 32'h00000001, 24'd0, 1'b0);
        chk("model_lsl32", mv, {1'b1, 32'h0});
        mv = model(2'd2, 12'h000, 8'd33, 32'h00000001, 24'd0, 1'b1);
        chk("model_lsl33", mv, {1'b0, 32'h0});
        mv = model(2'd2, 12'h000, 8'd0, 32'h00000001, 24'd0, 1'b1);
        chk("model_lsl0", mv, {1'b1, 32'h1});
        mv = model(2'd3, 12'h000, 8'd0, 32'h0, 24'hFFFFFE, 1'b0);
        chk("model_br_neg", mv, {1'b0, 32'hFFFFFFF8});
        mv = model(2'd3, 12'h000, 8'd0, 32'h0, 24'h000003, 1'b1);
        chk("model_br_pos", mv, {1'b1, 32'h0000000C});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_data", bus.shifted_data, 0);
        chk("rst_cout", bus.carry_out, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Test 1: latency and immediate rotate.
        send(2'd0, 12'h4FF, 8'd0, 32'h12345678, 24'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2", bus.out_valid, 1);
        chk("t1_data", bus.shifted_data, 32'hFF000000);
        chk("t1_cout", bus.carry_out, C_CARRY ? 1 : 0);
        drain("t1_drain");

        // Directed vectors, back to back.
        send(2'd0, 12'h0AB, 8'd0, 32'h0, 24'd0, 1'b1);
        send(2'd0, 12'h13F, 8'd0, 32'h0, 24'd0, 1'b0);
        send(2'd1, 12'h020, 8'd0, 32'h80000001, 24'd0, 1'b0);
        send(2'd1, 12'h060, 8'd0, 32'h00000003, 24'd0, 1'b1);
        send(2'd1, 12'h200, 8'd0, 32'h87654321, 24'd0, 1'b0);
        send(2'd1, 12'h000, 8'd0, 32'hDEADBEEF, 24'd0, 1'b1);
        send(2'd1, 12'h0C0, 8'd0, 32'hF0000010, 24'd0, 1'b0);
        send(2'd1, 12'h040, 8'd0, 32'h80000000, 24'd0, 1'b0);
        send(2'd1, 12'h460, 8'd0, 32'h12345678, 24'd0, 1'b0);
        send(2'd1, 12'hFA0, 8'd0, 32'hFFFF0000, 24'd0, 1'b0);
        send(2'd2, 12'h000, 8'd32, 32'h00000001, 24'd0, 1'b0);
        send(2'd2, 12'h000, 8'd33, 32'h00000001, 24'd0, 1'b1);
        send(2'd2, 12'h000, 8'd0, 32'h00000001, 24'd0, 1'b1);
        send(2'd2, 12'h000, 8'd31, 32'h00000003, 24'd0, 1'b0);
        send(2'd2, 12'h020, 8'd32, 32'h80000000, 24'd0, 1'b0);
        send(2'd2, 12'h020, 8'd33, 32'h80000000, 24'd0, 1'b1);
        send(2'd2, 12'h020, 8'd5, 32'h000000F0, 24'd0, 1'b0);
        send(2'd2, 12'h040, 8'd40, 32'h80000000, 24'd0, 1'b0);
        send(2'd2, 12'h040, 8'd32, 32'h7FFFFFFF, 24'd0, 1'b1);
        send(2'd2, 12'h060, 8'd32, 32'h80000001, 24'd0, 1'b0);
        send(2'd2, 12'h060, 8'd36, 32'h0000000F, 24'd0, 1'b0);
        send(2'd2, 12'h060, 8'd0, 32'h0000000F, 24'd0, 1'b0);
        send(2'd3, 12'h000, 8'd0, 32'h0, 24'hFFFFFE, 1'b1);
        send(2'd3, 12'h000, 8'd0, 32'h0, 24'h000003, 1'b0);
        send(2'd3, 12'h000, 8'd0, 32'h0, 24'h800000, 1'b1);
        bus.in_valid = 1'b0;
        drain("vec_drain");

        // Test 5: four back-to-back requests under back-pressure.
        base = n_drained;
        bus.out_ready = 1'b0;
        fork
            begin
                send(2'd1, 12'h200, 8'd0, 32'h0000000F, 24'd0, 1'b0);
                send(2'd2, 12'h020, 8'd4, 32'h00000100, 24'd0, 1'b0);
                send(2'd0, 12'h1FF, 8'd0, 32'h0, 24'd0, 1'b0);
                send(2'd3, 12'h000, 8'd0, 32'h0, 24'h000010, 1'b1);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("t5_drain");
        chk("t5_count", n_drained - base, 4);

        // Test 6: reset with both stages occupied.
        bus.out_ready = 1'b0;
        send(2'd1, 12'h200, 8'd0, 32'hFFFFFFFF, 24'd0, 1'b1);
        send(2'd2, 12'h000, 8'd1, 32'h80000000, 24'd0, 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_data", bus.shifted_data, 0);
        chk("rst_mid_cout", bus.carry_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;

        // Recovery after reset.
        base = n_drained;
        send(2'd1, 12'h0A0, 8'd0, 32'h00000005, 24'd0, 1'b0);
        bus.in_valid = 1'b0;
        drain("recover_drain");
        chk("recover_count", n_drained - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
